// File: rtl/udc_cfg_sequencer.sv
// udc_cfg_sequencer: host-side controller for the up/down cycle counter.
// Accepts one run command, writes PLR/ULR/LLR/CCR over the counter's
// chip-select/read/write bus, optionally reads them back and compares,
// pulses start, waits for end-of-count / range error / timeout, and returns
// a status response. Every output is a flop, so the bus strobes are glitch-free
// and the asynchronous reset takes them to their idle level immediately.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. cmd_ready is high only in IDLE. rsp_valid is held, together with a
// stable rsp_status/rsp_cycles, until the edge where rsp_ready is also high.
module udc_cfg_sequencer #(
  parameter int TIMEOUT = 4096,
  parameter int TW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_plr,
  input  logic [7:0]    cmd_ulr,
  input  logic [7:0]    cmd_llr,
  input  logic [7:0]    cmd_ccr,
  input  logic          cmd_verify,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_status,
  output logic [TW-1:0] rsp_cycles,
  output logic          ncs,
  output logic          nrd,
  output logic          nwr,
  output logic          a0,
  output logic          a1,
  output logic [7:0]    bus_wdata,
  output logic          bus_oe,
  input  logic [7:0]    bus_rdata,
  output logic          start,
  input  logic          ec,
  input  logic          err,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_TURN, S_RD, S_CHK, S_START, S_WAIT, S_RSP
  } state_t;

  localparam logic [1:0]    ST_OK      = 2'b00;
  localparam logic [1:0]    ST_RANGE   = 2'b01;
  localparam logic [1:0]    ST_VERIFY  = 2'b10;
  localparam logic [1:0]    ST_TIMEOUT = 2'b11;
  localparam logic [TW-1:0] TIMEOUT_C  = TW'(TIMEOUT);

  // control / data state
  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][7:0] cfg_q, cfg_d;     // [0]=PLR [1]=ULR [2]=LLR [3]=CCR
  logic            verify_q, verify_d;
  logic            mism_q, mism_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic [TW-1:0]   wcnt_inc;
  logic [1:0]      status_q, status_d;
  logic [TW-1:0]   cycles_q, cycles_d;

  // registered outputs
  logic            ncs_q, ncs_d;
  logic            nrd_q, nrd_d;
  logic            nwr_q, nwr_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            oe_q, oe_d;
  logic            start_q, start_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            busy_q, busy_d;

  assign wcnt_inc = wcnt_q + 1'b1;

  // State register: all state and output flops, async reset to IDLE with idle bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      cfg_q       <= '0;
      verify_q    <= 1'b0;
      mism_q      <= 1'b0;
      wcnt_q      <= '0;
      status_q    <= ST_OK;
      cycles_q    <= '0;
      ncs_q       <= 1'b1;
      nrd_q       <= 1'b1;
      nwr_q       <= 1'b1;
      addr_q      <= 2'd0;
      wdata_q     <= 8'd0;
      oe_q        <= 1'b0;
      start_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cfg_q       <= cfg_d;
      verify_q    <= verify_d;
      mism_q      <= mism_d;
      wcnt_q      <= wcnt_d;
      status_q    <= status_d;
      cycles_q    <= cycles_d;
      ncs_q       <= ncs_d;
      nrd_q       <= nrd_d;
      nwr_q       <= nwr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      oe_q        <= oe_d;
      start_q     <= start_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: sequencing, command capture, readback compare, wait counter, status
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cfg_d    = cfg_q;
    verify_d = verify_q;
    mism_d   = mism_q;
    wcnt_d   = wcnt_q;
    status_d = status_q;
    cycles_d = cycles_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cfg_d    = {cmd_ccr, cmd_llr, cmd_ulr, cmd_plr};
          verify_d = cmd_verify;
          mism_d   = 1'b0;
          idx_d    = 2'd0;
          state_d  = S_WR;
        end
      end
      S_WR: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = verify_q ? S_TURN : S_START;
      end
      S_TURN: begin
        idx_d   = 2'd0;
        state_d = S_RD;
      end
      S_RD: begin
        // read data is valid at the edge that ends the read cycle
        if (bus_rdata != cfg_q[idx_q]) mism_d = 1'b1;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_CHK;
      end
      S_CHK: begin
        if (mism_q) begin
          status_d = ST_VERIFY;
          cycles_d = '0;
          state_d  = S_RSP;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_inc;
        // counter flags are stale during the first WAIT cycle
        if ((wcnt_q != '0) && err) begin
          status_d = ST_RANGE;
          cycles_d = wcnt_inc;
          state_d  = S_RSP;
        end else if ((wcnt_q != '0) && ec) begin
          status_d = ST_OK;
          cycles_d = wcnt_inc;
          state_d  = S_RSP;
        end else if (wcnt_inc == TIMEOUT_C) begin
          status_d = ST_TIMEOUT;
          cycles_d = wcnt_inc;
          state_d  = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: decoded from the next state so the flops line up with the state
  always_comb begin
    ncs_d       = 1'b1;
    nrd_d       = 1'b1;
    nwr_d       = 1'b1;
    addr_d      = 2'd0;
    wdata_d     = 8'd0;
    oe_d        = 1'b0;
    start_d     = 1'b0;
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RSP);
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_WR: begin
        ncs_d   = 1'b0;
        nwr_d   = 1'b0;
        oe_d    = 1'b1;
        addr_d  = idx_d;
        wdata_d = cfg_d[idx_d];
      end
      S_RD: begin
        ncs_d  = 1'b0;
        nrd_d  = 1'b0;
        addr_d = idx_d;
      end
      S_START: start_d = 1'b1;
      default: ;
    endcase
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = status_q;
  assign rsp_cycles = cycles_q;
  assign ncs        = ncs_q;
  assign nrd        = nrd_q;
  assign nwr        = nwr_q;
  assign a0         = addr_q[0];
  assign a1         = addr_q[1];
  assign bus_wdata  = wdata_q;
  assign bus_oe     = oe_q;
  assign start      = start_q;
  assign busy       = busy_q;

endmodule

// File: doc/udc_cfg_sequencer.md
Name: udc_cfg_sequencer

Overview:
Host-side controller that programs and runs the up/down cycle counter over its 8-bit chip-select/read/write register bus.
- Takes one run command (PLR, ULR, LLR, CCR, verify flag) per valid/ready handshake.
- Writes the four registers, optionally reads them back and compares, pulses start, then waits for end-of-count or error.
- Returns a status response. Sits between a system master and the counter instance; bus tristating is done at the top level.

Parameters:
TIMEOUT, 4096, max cycles spent in WAIT before aborting with timeout status
TW, 16, width of wait-cycle counter and rsp_cycles; TIMEOUT must be < 2^TW

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_plr / cmd_ulr / cmd_llr / cmd_ccr  in  8 each  register values
cmd_verify  in  1  enable readback compare
rsp_valid  out  1  response available; held until rsp_ready
rsp_ready  in  1  response accepted
rsp_status  out  2  00 OK, 01 RANGE_ERR, 10 VERIFY_ERR, 11 TIMEOUT
rsp_cycles  out  TW  cycles spent in WAIT
ncs, nrd, nwr  out  1 each  counter bus strobes, active-low
a0, a1  out  1 each  register address (a1a0: 00 PLR, 01 ULR, 10 LLR, 11 CCR)
bus_wdata  out  8  write data
bus_oe  out  1  top-level drives din from bus_wdata when high
bus_rdata  in  8  din as seen at top level
start  out  1  one-cycle run pulse to counter
ec, err  in  1 each  counter end-of-count and range-error flags
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset state:
  - All outputs are registered. Reset forces IDLE immediately (asynchronously).
  - Reset values: ncs=nrd=nwr=1, a0=a1=0, bus_oe=0, bus_wdata=0, start=0, cmd_ready=1, rsp_valid=0, rsp_status=0, rsp_cycles=0, busy=0.
- Bus invariants:
  - nrd and nwr are never both low in the same cycle.
  - bus_oe=1 only when nwr=0.
  - Idle bus is ncs=nrd=nwr=1.
- IDLE: cmd_valid & cmd_ready captures the command into internal regs; go to WR with idx=0.
- WR, 4 cycles (idx 0..3, order PLR, ULR, LLR, CCR):
  - ncs=0, nwr=0, nrd=1, bus_oe=1, {a1,a0}=idx, bus_wdata=selected reg.
  - Counter samples each write at the edge ending the cycle.
  - After idx 3: go to TURN if verify is set, else START.
- TURN, 1 cycle: bus idle, bus_oe=0. This is the bus turnaround.
- RD, 4 cycles (idx 0..3):
  - ncs=0, nrd=0, nwr=1, bus_oe=0.
  - bus_rdata is sampled at the edge ending the cycle and compared to the captured value; any mismatch sets a sticky mismatch bit.
  - After idx 3: go to CHK.
- CHK, 1 cycle:
  - Mismatch: respond VERIFY_ERR and go to RSP. start is never asserted.
  - No mismatch: go to START.
- START, 1 cycle: start=1, bus idle. Clear the wait counter; go to WAIT.
- WAIT: bus idle, start=0. Increment wait counter every cycle. Evaluate in priority order:
  1. err=1 → RANGE_ERR.
  2. ec=1 → OK.
  3. Count reaches TIMEOUT → TIMEOUT.
  - err/ec are ignored only in the first WAIT cycle (counter flags update at the START edge).
  - rsp_cycles = count at exit.
- RSP:
  - rsp_valid=1; status and cycles stay stable until rsp_ready.
  - On handshake: rsp_valid=0, go to IDLE; cmd_ready=1 next cycle.
- Latency from accept to start: 5 cycles without verify, 11 cycles with verify.
- cmd fields, cmd_valid and rsp_ready are don't-care outside their handshake states.
- A counter still running after a TIMEOUT ignores writes. The controller does not detect this except through verify, which reports VERIFY_ERR.
- Reset mid-operation: bus strobes deassert without waiting for a clock edge; any pending response is discarded.

Test Plan:
1. PLR=5 ULR=8 LLR=2 CCR=1, verify=0:
   - Four consecutive write cycles: a1a0=00,01,10,11 with data 5,8,2,1.
   - start high for exactly 1 cycle, 5 cycles after accept.
   - ec eventually rises → rsp_status=00, rsp_cycles equals the counted WAIT cycles.
2. Same command with verify=1 against a real counter:
   - TURN gap seen, then four reads; start 11 cycles after accept; status 00.
   - Repeat with the bench forcing bus_rdata=0x07 during the ULR read → status 10, start never asserted.
3. PLR=10 ULR=8 LLR=2 CCR=3 → counter raises err after start → status 01 within 2 cycles of start.
4. TIMEOUT=16 with ec and err tied low → status 11, rsp_cycles=16, bus idle throughout WAIT.
5. Assert reset during WR idx 2 → ncs/nwr go high and bus_oe goes low before the next edge; cmd_ready=1 after reset release; a new command then writes all four registers from PLR.
6. Hold rsp_ready low 5 cycles → rsp_valid, status and cycles stable, cmd_ready=0; a cmd_valid presented at the handshake is accepted on the following cycle.
